tff_event_monitor: RTL and testbench



---
 rtl/tff_event_monitor.sv | 172 +++++++++++++++++
 tb/tb_tff_event_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tff_event_monitor.sv
// tff_event_monitor
// Samples the complementary q/qb outputs of the toggle flip-flop stage on
// every clk1 edge, counts rising edges of q as a two-digit BCD value, drives
// a seven-segment pattern for the units digit, and enters FAULT when q and qb
// are equal for ERR_LIMIT consecutive samples.
//
// Ports:
//   clk1   in   divided clock, all state updates on posedge
//   rst    in   synchronous active-high reset
//   clr    in   synchronous clear (lower priority than rst)
//   en     in   count enable
//   q_in   in   q from the T flip-flop stage
//   qb_in  in   qb from the T flip-flop stage
//   ones   out  BCD units digit (registered)
//   tens   out  BCD tens digit (registered)
//   seg    out  {g,f,e,d,c,b,a} active-high segments
//   rise   out  one-cycle pulse per counted rising edge
//   ovf    out  sticky overflow flag
//   err    out  high while in FAULT
//   state  out  00 IDLE, 01 RUN, 10 FAULT
module tff_event_monitor #(
  parameter int unsigned MAX_TENS  = 9,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       q_in,
  input  logic       qb_in,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] seg,
  output logic       rise,
  output logic       ovf,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [3:0] C_MAX_TENS  = 4'(MAX_TENS);
  localparam logic [3:0] C_ERR_LIMIT = 4'(ERR_LIMIT);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_ones, w_ones_nxt;
  logic [3:0] r_tens, w_tens_nxt;
  logic [3:0] r_bad_cnt, w_bad_cnt_nxt;
  logic       r_q_prev, w_q_prev_nxt;
  logic       r_rise, w_rise_nxt;
  logic       r_ovf, w_ovf_nxt;

  logic       w_valid;
  logic [3:0] w_bad_inc;

  assign w_valid   = (q_in != qb_in);
  assign w_bad_inc = r_bad_cnt + 4'd1;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ones    <= '0;
      r_tens    <= '0;
      r_bad_cnt <= '0;
      r_q_prev  <= 1'b0;
      r_rise    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ones    <= w_ones_nxt;
      r_tens    <= w_tens_nxt;
      r_bad_cnt <= w_bad_cnt_nxt;
      r_q_prev  <= w_q_prev_nxt;
      r_rise    <= w_rise_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ones_nxt    = r_ones;
    w_tens_nxt    = r_tens;
    w_bad_cnt_nxt = r_bad_cnt;
    w_q_prev_nxt  = r_q_prev;
    w_rise_nxt    = 1'b0;
    w_ovf_nxt     = r_ovf;

    if (clr) begin
      w_state_nxt   = IDLE;
      w_ones_nxt    = '0;
      w_tens_nxt    = '0;
      w_bad_cnt_nxt = '0;
      w_q_prev_nxt  = 1'b0;
      w_ovf_nxt     = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            w_q_prev_nxt = q_in;
            w_state_nxt  = RUN;
          end
        end
        RUN: begin
          if (w_valid) begin
            w_bad_cnt_nxt = '0;
            w_q_prev_nxt  = q_in;
            if (!r_q_prev && q_in && en) begin
              w_rise_nxt = 1'b1;
              if (r_ones == 4'd9) begin
                w_ones_nxt = '0;
                if (r_tens == C_MAX_TENS) begin
                  w_tens_nxt = '0;
                  w_ovf_nxt  = 1'b1;
                end else begin
                  w_tens_nxt = r_tens + 4'd1;
                end
              end else begin
                w_ones_nxt = r_ones + 4'd1;
              end
            end
          end else begin
            // q_prev is held so a short invalid gap between a valid 0 and
            // a valid 1 still counts as one rising edge.
            w_bad_cnt_nxt = w_bad_inc;
            if (w_bad_inc == C_ERR_LIMIT) begin
              w_state_nxt = FAULT;
            end
          end
        end
        FAULT: begin
          // Frozen until clr or rst.
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    seg = 7'h00;
    if (r_state == FAULT) begin
      seg = 7'h79;
    end else begin
      case (r_ones)
        4'd0:    seg = 7'h3F;
        4'd1:    seg = 7'h06;
        4'd2:    seg = 7'h5B;
        4'd3:    seg = 7'h4F;
        4'd4:    seg = 7'h66;
        4'd5:    seg = 7'h6D;
        4'd6:    seg = 7'h7D;
        4'd7:    seg = 7'h07;
        4'd8:    seg = 7'h7F;
        4'd9:    seg = 7'h6F;
        default: seg = 7'h00;
      endcase
    end
  end

  assign ones  = r_ones;
  assign tens  = r_tens;
  assign rise  = r_rise;
  assign ovf   = r_ovf;
  assign err   = (r_state == FAULT);
  assign state = r_state;

endmodule

// File: tb/tb_tff_event_monitor.sv
module tb_tff_event_monitor;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en = 1'b1;
  logic       q_in = 1'b0;
  logic       qb_in = 1'b1;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] seg;
  logic       rise;
  logic       ovf;
  logic       err;
  logic [1:0] state;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned rise_cnt = 0;

  tff_event_monitor #(
    .MAX_TENS (1),
    .ERR_LIMIT(3)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .q_in (q_in),
    .qb_in(qb_in),
    .ones (ones),
    .tens (tens),
    .seg  (seg),
    .rise (rise),
    .ovf  (ovf),
    .err  (err),
    .state(state)
  );

  always #5 clk1 = ~clk1;

  // Drive one sample, let it be taken at the next posedge, settle 1 time unit.
  task automatic step(input logic q, input logic qb);
    q_in  = q;
    qb_in = qb;
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valid 0 then valid 1; tallies rise pulses seen after the q=1 sample.
  task automatic edge_pair();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    if (rise) rise_cnt++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ones"},  32'(ones),  32'h0);
    chk({tag, "_tens"},  32'(tens),  32'h0);
    chk({tag, "_rise"},  32'(rise),  32'h0);
    chk({tag, "_ovf"},   32'(ovf),   32'h0);
    chk({tag, "_err"},   32'(err),   32'h0);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_seg"},   32'(seg),   32'h3F);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    chk_reset("reset");

    // Basic count: first valid sample only leaves IDLE
    step(1'b0, 1'b1);
    chk("idle_to_run_state", 32'(state), 32'h1);
    chk("idle_to_run_ones",  32'(ones),  32'h0);
    step(1'b1, 1'b0);
    chk("first_rise", 32'(rise), 32'h1);
    chk("first_ones", 32'(ones), 32'h1);
    rise_cnt = 1;
    step(1'b0, 1'b1);
    chk("rise_one_cycle", 32'(rise), 32'h0);
    for (int i = 0; i < 11; i++) edge_pair();
    chk("cnt12_rises", rise_cnt, 32'd12);
    chk("cnt12_ones",  32'(ones), 32'h2);
    chk("cnt12_tens",  32'(tens), 32'h1);
    chk("cnt12_seg",   32'(seg),  32'h5B);
    chk("cnt12_ovf",   32'(ovf),  32'h0);

    // Overflow with MAX_TENS=1
    for (int i = 0; i < 7; i++) edge_pair();
    chk("cnt19_ones", 32'(ones), 32'h9);
    chk("cnt19_tens", 32'(tens), 32'h1);
    chk("cnt19_seg",  32'(seg),  32'h6F);
    edge_pair();
    chk("ovf_ones", 32'(ones), 32'h0);
    chk("ovf_tens", 32'(tens), 32'h0);
    chk("ovf_flag", 32'(ovf),  32'h1);
    chk("ovf_rise", 32'(rise), 32'h1);
    edge_pair();
    chk("post_ovf_ones",   32'(ones), 32'h1);
    chk("post_ovf_sticky", 32'(ovf),  32'h1);

    // Fault entry: 2 invalid, 1 valid (restart), 3 invalid
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("two_bad_state", 32'(state), 32'h1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("restart_state", 32'(state), 32'h1);
    chk("restart_err",   32'(err),   32'h0);
    step(1'b0, 1'b0);
    chk("fault_state", 32'(state), 32'h2);
    chk("fault_err",   32'(err),   32'h1);
    chk("fault_seg",   32'(seg),   32'h79);
    edge_pair();
    chk("fault_frozen_ones", 32'(ones),  32'h1);
    chk("fault_frozen_tens", 32'(tens),  32'h0);
    chk("fault_frozen_ovf",  32'(ovf),   32'h1);
    chk("fault_no_rise",     32'(rise),  32'h0);
    chk("fault_held",        32'(state), 32'h2);

    // Reset mid-FAULT with invalid inputs
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    chk_reset("rst_fault");

    // Enable gating: 3 edges with en=0, then 2 with en=1
    en = 1'b0;
    for (int i = 0; i < 3; i++) edge_pair();
    chk("en0_ones", 32'(ones), 32'h0);
    chk("en0_rise", 32'(rise), 32'h0);
    en = 1'b1;
    edge_pair();
    edge_pair();
    chk("en1_ones", 32'(ones), 32'h2);

    // Invalid gap between valid 0 and valid 1 still counts
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("gap_ones", 32'(ones), 32'h3);
    chk("gap_rise", 32'(rise), 32'h1);

    // Count to 07, then clr coincident with a qualifying edge
    for (int i = 0; i < 4; i++) edge_pair();
    chk("cnt07_ones", 32'(ones), 32'h7);
    chk("cnt07_seg",  32'(seg),  32'h07);
    step(1'b0, 1'b1);
    clr = 1'b1;
    step(1'b1, 1'b0);
    clr = 1'b0;
    chk("clr_ones",  32'(ones),  32'h0);
    chk("clr_tens",  32'(tens),  32'h0);
    chk("clr_state", 32'(state), 32'h0);
    chk("clr_rise",  32'(rise),  32'h0);
    step(1'b1, 1'b0);
    chk("after_clr_state", 32'(state), 32'h1);
    chk("after_clr_ones",  32'(ones),  32'h0);
    chk("after_clr_rise",  32'(rise),  32'h0);
    edge_pair();
    chk("after_clr_count", 32'(ones), 32'h1);

    // clr is the way out of FAULT
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("fault2_state", 32'(state), 32'h2);
    clr = 1'b1;
    step(1'b1, 1'b1);
    clr = 1'b0;
    chk("clr_fault_state", 32'(state), 32'h0);
    chk("clr_fault_err",   32'(err),   32'h0);
    chk("clr_fault_seg",   32'(seg),   32'h3F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
